// File: rtl/issue_scoreboard_pkg.sv
// Shared types and defaults for the decode-stage issue scoreboard.
// Holds the FSM encoding, the counter type and the retire/kill slot record.
package issue_scoreboard_pkg;

    localparam int SB_NREG   = 32;
    localparam int SB_CNT_W  = 2;
    localparam int SB_PERF_W = 32;
    localparam int SB_REG_W  = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_CSR_WAIT = 2'd1,
        ST_DRAIN    = 2'd2
    } sb_state_t;

    typedef logic [SB_CNT_W-1:0] sb_cnt_t;

    typedef struct packed {
        logic                valid;
        logic                wen;
        logic                iscsr;
        logic [SB_REG_W-1:0] dst;
    } kill_slot_t;

    // True when a completing/squashed slot releases one write to register r.
    function automatic logic slot_hits(kill_slot_t s, logic [SB_REG_W-1:0] r);
        return s.valid & s.wen & (s.dst == r);
    endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode/writeback/branch-kill bundle seen by the issue scoreboard.
// master = pipeline side driving requests, slave = the scoreboard.
interface issue_scoreboard_if #(
    parameter int NREG   = 32,
    parameter int PERF_W = 32
);
    logic              issue_valid;
    logic [4:0]        issue_ra1;
    logic [4:0]        issue_ra2;
    logic              issue_use1;
    logic              issue_use2;
    logic [4:0]        issue_dst;
    logic              issue_wen;
    logic              issue_iscsr;
    logic              issue_fence;
    logic              issue_ready;
    logic              retire_valid;
    logic              retire_wen;
    logic              retire_iscsr;
    logic [4:0]        retire_dst;
    logic              flush;
    logic              kill0_valid;
    logic              kill0_wen;
    logic              kill0_iscsr;
    logic [4:0]        kill0_dst;
    logic              kill1_valid;
    logic              kill1_wen;
    logic              kill1_iscsr;
    logic [4:0]        kill1_dst;
    logic [NREG-1:0]   busy_vec;
    logic [PERF_W-1:0] stall_cycles;
    logic              sb_err;

    modport master (
        output issue_valid, issue_ra1, issue_ra2, issue_use1, issue_use2,
               issue_dst, issue_wen, issue_iscsr, issue_fence,
               retire_valid, retire_wen, retire_iscsr, retire_dst, flush,
               kill0_valid, kill0_wen, kill0_iscsr, kill0_dst,
               kill1_valid, kill1_wen, kill1_iscsr, kill1_dst,
        input  issue_ready, busy_vec, stall_cycles, sb_err
    );

    modport slave (
        input  issue_valid, issue_ra1, issue_ra2, issue_use1, issue_use2,
               issue_dst, issue_wen, issue_iscsr, issue_fence,
               retire_valid, retire_wen, retire_iscsr, retire_dst, flush,
               kill0_valid, kill0_wen, kill0_iscsr, kill0_dst,
               kill1_valid, kill1_wen, kill1_iscsr, kill1_dst,
        output issue_ready, busy_vec, stall_cycles, sb_err
    );
endinterface

// File: rtl/issue_scoreboard_sb_regcnt.sv
// One per-register in-flight write counter: one increment, up to three
// decrements per cycle, clamped to [0, MAX], flagging underflow.
module sb_regcnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic [2:0]       dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             uflow_o
);
    localparam logic [CNT_W+1:0] MAX_W = {2'b00, {CNT_W{1'b1}}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W+1:0] up_s;
    logic [CNT_W+1:0] ndec_s;
    logic [CNT_W+1:0] net_s;

    // Net change with two guard bits so clamping sees the true result.
    always_comb begin
        up_s    = {2'b00, cnt_q} + (CNT_W+2)'(inc_i);
        ndec_s  = (CNT_W+2)'(dec_i[0]) + (CNT_W+2)'(dec_i[1]) + (CNT_W+2)'(dec_i[2]);
        net_s   = up_s - ndec_s;
        uflow_o = (up_s < ndec_s);
        if (uflow_o) begin
            cnt_d = '0;
        end else if (net_s > MAX_W) begin
            cnt_d = {CNT_W{1'b1}};
        end else begin
            cnt_d = net_s[CNT_W-1:0];
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/issue_scoreboard.sv
// Decode-stage issue controller: per-GPR in-flight write counters for RAW
// hazards plus a CSR/fence serialising FSM, stall counter and underflow flag.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int NREG   = SB_NREG,
    parameter int CNT_W  = SB_CNT_W,
    parameter int PERF_W = SB_PERF_W
) (
    input  logic             clk,
    input  logic             reset,
    issue_scoreboard_if.slave sb
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0]  cnt_s [NREG];
    logic [NREG-1:0]   busy_s;
    logic [NREG-1:0]   uflow_s;
    kill_slot_t        ret_s;
    kill_slot_t        k0_s;
    kill_slot_t        k1_s;
    logic              raw_s;
    logic              sat_s;
    logic              any_busy_s;
    logic              fence_block_s;
    logic              csr_done_s;
    logic              ready_s;
    logic              fire_s;
    sb_state_t         state_q;
    sb_state_t         state_d;
    logic [PERF_W-1:0] stall_q;
    logic [PERF_W-1:0] stall_d;
    logic              err_q;
    logic              err_d;

    assign ret_s = {sb.retire_valid, sb.retire_wen, sb.retire_iscsr, sb.retire_dst};
    assign k0_s  = {sb.kill0_valid, sb.kill0_wen, sb.kill0_iscsr, sb.kill0_dst};
    assign k1_s  = {sb.kill1_valid, sb.kill1_wen, sb.kill1_iscsr, sb.kill1_dst};

    // x0 is never tracked, so its counter reads as permanently empty.
    assign cnt_s[0]   = '0;
    assign busy_s[0]  = 1'b0;
    assign uflow_s[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        sb_regcnt #(.CNT_W(CNT_W)) u_cnt (
            .clk     (clk),
            .rst_n   (reset),
            .inc_i   (fire_s & sb.issue_wen & (sb.issue_dst == SB_REG_W'(r))),
            .dec_i   ({slot_hits(k1_s, SB_REG_W'(r)),
                       slot_hits(k0_s, SB_REG_W'(r)),
                       slot_hits(ret_s, SB_REG_W'(r))}),
            .cnt_o   (cnt_s[r]),
            .uflow_o (uflow_s[r])
        );
        assign busy_s[r] = |cnt_s[r];
    end

    // Readiness depends only on registered counters/state and decode inputs.
    always_comb begin
        raw_s = (sb.issue_use1 & (sb.issue_ra1 != 5'd0) & (cnt_s[sb.issue_ra1] != '0))
              | (sb.issue_use2 & (sb.issue_ra2 != 5'd0) & (cnt_s[sb.issue_ra2] != '0));
        sat_s = sb.issue_wen & (sb.issue_dst != 5'd0) & (cnt_s[sb.issue_dst] == CNT_MAX);
        any_busy_s    = |busy_s;
        fence_block_s = sb.issue_valid & sb.issue_fence & any_busy_s;
        csr_done_s    = (ret_s.valid & ret_s.iscsr) | (k0_s.valid & k0_s.iscsr)
                      | (k1_s.valid & k1_s.iscsr);
        ready_s = (state_q == ST_RUN) & ~sb.flush & ~raw_s & ~sat_s & ~fence_block_s;
        fire_s  = sb.issue_valid & ready_s;
    end

    // Serialising FSM next state plus perf/error next values.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (fire_s & sb.issue_iscsr) begin
                    state_d = ST_CSR_WAIT;
                end else if (fence_block_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_CSR_WAIT: begin
                if (csr_done_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_CSR_WAIT;
                end
            end
            ST_DRAIN: begin
                if (~any_busy_s | sb.flush) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        if (sb.issue_valid & ~ready_s & ~sb.flush) begin
            stall_d = stall_q + PERF_W'(1);
        end else begin
            stall_d = stall_q;
        end
        err_d = err_q | (|uflow_s);
    end

    // State, stall counter and sticky error registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign sb.issue_ready  = ready_s;
    assign sb.busy_vec     = busy_s;
    assign sb.stall_cycles = stall_q;
    assign sb.sb_err       = err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed scenario table, async-reset sequence,
// then randomized traffic against a counter-array reference model.
module tb_issue_scoreboard;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    issue_scoreboard_if #(.NREG(32), .PERF_W(32)) sb_if ();

    issue_scoreboard u_dut (
        .clk   (clk),
        .reset (rst_n),
        .sb    (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  ra1;
        logic        u1;
        logic [4:0]  dst;
        logic        wen;
        logic        csr;
        logic        fence;
        logic        flush;
        logic        rv;
        logic [4:0]  rdst;
        logic        k0v;
        logic        k0wen;
        logic        k0csr;
        logic [4:0]  k0dst;
        logic        exp_ready;
        logic [31:0] exp_busy;
        int          exp_stall;
        logic        exp_err;
    } vec_t;

    function automatic vec_t mk(int v, int ra1, int u1, int dst, int wen, int csr,
                                int fence, int flush, int rv, int rdst, int k0v,
                                int k0wen, int k0csr, int k0dst, int er,
                                logic [31:0] eb, int es, int ee);
        vec_t t;
        t.v = 1'(v); t.ra1 = 5'(ra1); t.u1 = 1'(u1); t.dst = 5'(dst);
        t.wen = 1'(wen); t.csr = 1'(csr); t.fence = 1'(fence); t.flush = 1'(flush);
        t.rv = 1'(rv); t.rdst = 5'(rdst); t.k0v = 1'(k0v); t.k0wen = 1'(k0wen);
        t.k0csr = 1'(k0csr); t.k0dst = 5'(k0dst); t.exp_ready = 1'(er);
        t.exp_busy = eb; t.exp_stall = es; t.exp_err = 1'(ee);
        return t;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic idle_inputs();
        sb_if.issue_valid = 1'b0; sb_if.issue_ra1 = 5'd0; sb_if.issue_ra2 = 5'd0;
        sb_if.issue_use1 = 1'b0; sb_if.issue_use2 = 1'b0; sb_if.issue_dst = 5'd0;
        sb_if.issue_wen = 1'b0; sb_if.issue_iscsr = 1'b0; sb_if.issue_fence = 1'b0;
        sb_if.retire_valid = 1'b0; sb_if.retire_wen = 1'b0; sb_if.retire_iscsr = 1'b0;
        sb_if.retire_dst = 5'd0; sb_if.flush = 1'b0;
        sb_if.kill0_valid = 1'b0; sb_if.kill0_wen = 1'b0; sb_if.kill0_iscsr = 1'b0;
        sb_if.kill0_dst = 5'd0; sb_if.kill1_valid = 1'b0; sb_if.kill1_wen = 1'b0;
        sb_if.kill1_iscsr = 1'b0; sb_if.kill1_dst = 5'd0;
    endtask

    task automatic drive_vec(vec_t t);
        idle_inputs();
        sb_if.issue_valid = t.v; sb_if.issue_ra1 = t.ra1; sb_if.issue_use1 = t.u1;
        sb_if.issue_dst = t.dst; sb_if.issue_wen = t.wen; sb_if.issue_iscsr = t.csr;
        sb_if.issue_fence = t.fence; sb_if.flush = t.flush;
        sb_if.retire_valid = t.rv; sb_if.retire_wen = t.rv; sb_if.retire_dst = t.rdst;
        sb_if.kill0_valid = t.k0v; sb_if.kill0_wen = t.k0wen;
        sb_if.kill0_iscsr = t.k0csr; sb_if.kill0_dst = t.k0dst;
    endtask

    // Reference model: plain integer counters and a symbolic mode.
    localparam int M_RUN = 0, M_CSR = 1, M_DRAIN = 2;
    int m_cnt [32];
    int m_mode;
    int m_stall;
    bit m_err;

    function automatic bit m_any();
        for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b = 32'd0;
        for (int r = 1; r < 32; r++) b[r] = (m_cnt[r] > 0);
        return b;
    endfunction

    function automatic bit m_ready();
        bit blocked;
        if (m_mode != M_RUN || sb_if.flush) return 1'b0;
        blocked = (sb_if.issue_use1 && sb_if.issue_ra1 != 0 && m_cnt[sb_if.issue_ra1] > 0)
               || (sb_if.issue_use2 && sb_if.issue_ra2 != 0 && m_cnt[sb_if.issue_ra2] > 0)
               || (sb_if.issue_wen && sb_if.issue_dst != 0 && m_cnt[sb_if.issue_dst] == 3)
               || (sb_if.issue_valid && sb_if.issue_fence && m_any());
        return !blocked;
    endfunction

    task automatic m_step(bit rdy);
        bit fire = sb_if.issue_valid && rdy;
        bit was_any = m_any();
        for (int r = 1; r < 32; r++) begin
            int n = m_cnt[r];
            if (fire && sb_if.issue_wen && sb_if.issue_dst == r) n++;
            if (sb_if.retire_valid && sb_if.retire_wen && sb_if.retire_dst == r) n--;
            if (sb_if.kill0_valid && sb_if.kill0_wen && sb_if.kill0_dst == r) n--;
            if (sb_if.kill1_valid && sb_if.kill1_wen && sb_if.kill1_dst == r) n--;
            if (n < 0) begin m_err = 1'b1; n = 0; end
            if (n > 3) n = 3;
            m_cnt[r] = n;
        end
        if (sb_if.issue_valid && !rdy && !sb_if.flush) m_stall++;
        if (m_mode == M_RUN) begin
            if (fire && sb_if.issue_iscsr) m_mode = M_CSR;
            else if (sb_if.issue_valid && sb_if.issue_fence && was_any) m_mode = M_DRAIN;
        end else if (m_mode == M_CSR) begin
            if ((sb_if.retire_valid && sb_if.retire_iscsr) || (sb_if.kill0_valid && sb_if.kill0_iscsr)
                || (sb_if.kill1_valid && sb_if.kill1_iscsr)) m_mode = M_RUN;
        end else begin
            if (!was_any || sb_if.flush) m_mode = M_RUN;
        end
    endtask

    function automatic int pick_busy();
        int cands[$];
        for (int r = 1; r < 8; r++) if (m_cnt[r] > 0) cands.push_back(r);
        if (cands.size() == 0 || $urandom_range(0, 49) == 0) return $urandom_range(0, 7);
        return cands[$urandom_range(0, cands.size() - 1)];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_mode = M_RUN; m_stall = 0; m_err = 1'b0;
    endtask

    vec_t tbl [$];

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        idle_inputs();
        #12;
        chk("rst_ready", 64'(sb_if.issue_ready), 64'd1);
        chk("rst_busy", 64'(sb_if.busy_vec), 64'd0);
        chk("rst_stall", 64'(sb_if.stall_cycles), 64'd0);
        chk("rst_err", 64'(sb_if.sb_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //           v ra u dst w c f fl rv rd k0v kw kc kd  rdy busy        stall err
        tbl.push_back(mk(1,0,0, 5,1,0,0,0, 0,0, 0,0,0,0,  1,32'h0,     0,0)); // addi x5
        tbl.push_back(mk(1,5,1, 6,1,0,0,0, 0,0, 0,0,0,0,  0,32'h20,    0,0)); // add x6,x5
        tbl.push_back(mk(1,5,1, 6,1,0,0,0, 1,5, 0,0,0,0,  0,32'h20,    1,0)); // retire x5, no bypass
        tbl.push_back(mk(1,5,1, 6,1,0,0,0, 0,0, 0,0,0,0,  1,32'h0,     2,0));
        tbl.push_back(mk(1,0,0, 7,1,0,0,0, 0,0, 0,0,0,0,  1,32'h40,    2,0)); // x7 writers
        tbl.push_back(mk(1,0,0, 7,1,0,0,0, 0,0, 0,0,0,0,  1,32'hC0,    2,0));
        tbl.push_back(mk(1,0,0, 7,1,0,0,0, 0,0, 0,0,0,0,  1,32'hC0,    2,0));
        tbl.push_back(mk(1,0,0, 7,1,0,0,0, 0,0, 0,0,0,0,  0,32'hC0,    2,0)); // saturated
        tbl.push_back(mk(1,0,0, 7,1,0,0,0, 1,7, 0,0,0,0,  0,32'hC0,    3,0));
        tbl.push_back(mk(1,0,0, 7,1,0,0,0, 0,0, 0,0,0,0,  1,32'hC0,    4,0));
        tbl.push_back(mk(0,0,0, 0,0,0,0,0, 1,6, 0,0,0,0,  1,32'hC0,    4,0));
        tbl.push_back(mk(0,0,0, 0,0,0,0,0, 1,7, 0,0,0,0,  1,32'h80,    4,0));
        tbl.push_back(mk(0,0,0, 0,0,0,0,0, 1,7, 0,0,0,0,  1,32'h80,    4,0));
        tbl.push_back(mk(0,0,0, 0,0,0,0,0, 1,7, 0,0,0,0,  1,32'h80,    4,0));
        tbl.push_back(mk(1,0,0, 9,1,0,0,0, 0,0, 0,0,0,0,  1,32'h0,     4,0)); // x9 = 1
        tbl.push_back(mk(1,0,0, 9,1,0,0,0, 1,9, 0,0,0,0,  1,32'h200,   4,0)); // inc+dec
        tbl.push_back(mk(0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0,  1,32'h200,   4,0));
        tbl.push_back(mk(1,0,0, 0,0,1,0,0, 0,0, 0,0,0,0,  1,32'h200,   4,0)); // CSR fires
        tbl.push_back(mk(1,0,0,11,1,0,0,0, 0,0, 0,0,0,0,  0,32'h200,   4,0));
        tbl.push_back(mk(1,0,0,11,1,0,0,0, 0,0, 1,0,1,0,  0,32'h200,   5,0)); // kill CSR
        tbl.push_back(mk(1,0,0,11,1,0,0,0, 0,0, 0,0,0,0,  1,32'h200,   6,0));
        tbl.push_back(mk(0,0,0, 0,0,0,0,0, 1,9, 1,1,0,11, 1,32'hA00,   6,0));
        tbl.push_back(mk(1,0,0, 3,1,0,0,0, 0,0, 0,0,0,0,  1,32'h0,     6,0)); // x3 = 2
        tbl.push_back(mk(1,0,0, 3,1,0,0,0, 0,0, 0,0,0,0,  1,32'h8,     6,0));
        tbl.push_back(mk(1,0,0, 0,0,0,1,0, 0,0, 0,0,0,0,  0,32'h8,     6,0)); // fence -> DRAIN
        tbl.push_back(mk(1,0,0, 0,0,0,1,0, 1,3, 0,0,0,0,  0,32'h8,     7,0));
        tbl.push_back(mk(1,0,0, 0,0,0,1,0, 1,3, 0,0,0,0,  0,32'h8,     8,0));
        tbl.push_back(mk(1,0,0, 0,0,0,1,0, 0,0, 0,0,0,0,  0,32'h0,     9,0));
        tbl.push_back(mk(1,0,0, 0,0,0,1,0, 0,0, 0,0,0,0,  1,32'h0,    10,0)); // fence fires
        tbl.push_back(mk(0,0,0, 0,0,0,0,0, 1,4, 0,0,0,0,  1,32'h0,    10,0)); // underflow
        tbl.push_back(mk(0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0,  1,32'h0,    10,1));
        tbl.push_back(mk(1,0,0,12,1,0,0,1, 0,0, 0,0,0,0,  0,32'h0,    10,1)); // flushed
        tbl.push_back(mk(0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0,  1,32'h0,    10,1));
        tbl.push_back(mk(1,12,1,0,0,0,0,0, 0,0, 0,0,0,0,  1,32'h0,    10,1));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive_vec(tbl[i]);
            #1;
            chk($sformatf("tbl%0d_ready", i), 64'(sb_if.issue_ready), 64'(tbl[i].exp_ready));
            chk($sformatf("tbl%0d_busy", i), 64'(sb_if.busy_vec), 64'(tbl[i].exp_busy));
            chk($sformatf("tbl%0d_stall", i), 64'(sb_if.stall_cycles), 64'(tbl[i].exp_stall));
            chk($sformatf("tbl%0d_err", i), 64'(sb_if.sb_err), 64'(tbl[i].exp_err));
        end

        // Asynchronous reset while draining for a fence; sb_err is set here.
        @(negedge clk);
        idle_inputs();
        sb_if.issue_valid = 1'b1; sb_if.issue_dst = 5'd3; sb_if.issue_wen = 1'b1;
        @(negedge clk);
        idle_inputs();
        sb_if.issue_valid = 1'b1; sb_if.issue_fence = 1'b1;
        #1;
        chk("drain_enter_ready", 64'(sb_if.issue_ready), 64'd0);
        @(negedge clk);
        #1;
        chk("drain_hold_ready", 64'(sb_if.issue_ready), 64'd0);
        chk("drain_busy", 64'(sb_if.busy_vec), 64'h8);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(sb_if.busy_vec), 64'd0);
        chk("arst_err", 64'(sb_if.sb_err), 64'd0);
        chk("arst_stall", 64'(sb_if.stall_cycles), 64'd0);
        chk("arst_ready", 64'(sb_if.issue_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_fence_ready", 64'(sb_if.issue_ready), 64'd1);

        // Randomized traffic on x0..x7 against the reference model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            bit rdy;
            @(negedge clk);
            sb_if.issue_valid  = ($urandom_range(0, 9) < 7);
            sb_if.issue_ra1    = 5'($urandom_range(0, 7));
            sb_if.issue_ra2    = 5'($urandom_range(0, 7));
            sb_if.issue_use1   = 1'($urandom_range(0, 1));
            sb_if.issue_use2   = 1'($urandom_range(0, 1));
            sb_if.issue_dst    = 5'($urandom_range(0, 7));
            sb_if.issue_wen    = ($urandom_range(0, 9) < 7);
            sb_if.issue_iscsr  = ($urandom_range(0, 19) == 0);
            sb_if.issue_fence  = ($urandom_range(0, 19) == 0);
            sb_if.flush        = ($urandom_range(0, 19) == 0);
            sb_if.retire_valid = ($urandom_range(0, 9) < 4);
            sb_if.retire_wen   = ($urandom_range(0, 9) < 9);
            sb_if.retire_dst   = 5'(pick_busy());
            sb_if.retire_iscsr = (m_mode == M_CSR) ? ($urandom_range(0, 3) == 0)
                                                   : ($urandom_range(0, 29) == 0);
            sb_if.kill0_valid  = ($urandom_range(0, 9) == 0);
            sb_if.kill0_wen    = ($urandom_range(0, 3) != 0);
            sb_if.kill0_dst    = 5'(pick_busy());
            sb_if.kill0_iscsr  = (m_mode == M_CSR) && ($urandom_range(0, 7) == 0);
            sb_if.kill1_valid  = ($urandom_range(0, 9) == 0);
            sb_if.kill1_wen    = ($urandom_range(0, 3) != 0);
            sb_if.kill1_dst    = 5'(pick_busy());
            sb_if.kill1_iscsr  = (m_mode == M_CSR) && ($urandom_range(0, 7) == 0);
            rdy = m_ready();
            #1;
            chk("rnd_ready", 64'(sb_if.issue_ready), 64'(rdy));
            chk("rnd_busy", 64'(sb_if.busy_vec), 64'(m_busy()));
            chk("rnd_stall", 64'(sb_if.stall_cycles), 64'(m_stall));
            chk("rnd_err", 64'(sb_if.sb_err), 64'(m_err));
            m_step(rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Register-dependency scoreboard and issue controller for the decode stage.
- Replaces per-stage destination compares with per-GPR in-flight write counters and a CSR/fence serialising FSM.
- Decode presents one instruction per cycle; the block answers issue_ready, and decode stalls while valid & ~ready.
- Writeback retires writes and the branch unit kills squashed in-flight instructions.

Parameters:
NREG, 32, number of architectural GPRs; x0 never tracked.
CNT_W, 2, width of each per-register in-flight counter; saturates at 2^CNT_W-1.
PERF_W, 32, width of the stall-cycle counter.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-low reset (asserted at 0).
issue_valid  in  1  decode holds a valid instruction.
issue_ra1, issue_ra2  in  5  source register indices.
issue_use1, issue_use2  in  1  source actually read.
issue_dst  in  5  destination index.
issue_wen  in  1  instruction writes issue_dst.
issue_iscsr  in  1  CSR/CSRI instruction.
issue_fence  in  1  instruction requires an empty pipeline.
issue_ready  out  1  instruction may leave decode this cycle.
retire_valid, retire_wen, retire_iscsr  in  1  writeback completes an instruction.
retire_dst  in  5  writeback destination.
flush  in  1  branch redirect; the decode instruction is wrong-path.
kill0_valid, kill0_wen, kill0_iscsr, kill1_valid, kill1_wen, kill1_iscsr  in  1  up to two squashed in-flight instructions.
kill0_dst, kill1_dst  in  5  destinations of the squashed instructions.
busy_vec  out  NREG  bit r = cnt[r] != 0.
stall_cycles  out  PERF_W  count of valid & ~ready cycles.
sb_err  out  1  sticky counter-underflow error.

Behaviour:
- Reset (async, on reset==0):
  - all cnt[r]=0; state=RUN; stall_cycles=0; sb_err=0.
  - busy_vec=0.
  - issue_ready=1 while flush=0.
- fire = issue_valid & issue_ready.
- issue_ready is combinational from registered state only. There is no retire bypass: a retire in cycle t unblocks a reader in cycle t+1, consistent with the regfile write at the edge.
- RAW hazard: (issue_use1 & ra1!=0 & cnt[ra1]!=0) | (issue_use2 & ra2!=0 & cnt[ra2]!=0).
- Saturation hazard: issue_wen & dst!=0 & cnt[dst]==MAX.
- issue_ready = ~flush & ~RAW & ~saturation, gated further by the FSM state.
- FSM:
  - RUN: ready per the hazard rules above.
    - If issue_iscsr & fire, go to CSR_WAIT.
    - If issue_valid & issue_fence & any cnt!=0, go to DRAIN with ready=0.
    - A fence with an empty scoreboard fires in RUN.
  - CSR_WAIT: ready=0.
    - Return to RUN on (retire_valid & retire_iscsr) or (killN_valid & killN_iscsr).
  - DRAIN: ready=0.
    - Return to RUN when all cnt==0 or flush.
    - The fence fires in RUN on the next cycle.
- flush has priority over fire (no increment) and forces CSR_WAIT/DRAIN to RUN only via the kill/empty rules above. flush alone does not release CSR_WAIT.
- Counter update per r!=0: next = cnt + inc - dec_ret - dec_k0 - dec_k1, where:
  - inc = fire & wen & dst==r;
  - each dec term = valid & wen & dst==r.
- Simultaneous inc and dec on the same register yields net 0.
- Underflow: a decrement of a zero counter clamps at 0 and sets sb_err (cleared only by reset).
- stall_cycles increments when issue_valid & ~issue_ready & ~flush, and wraps at 2^PERF_W.
- Writes to x0 never change any counter.

Decomposition:
- Package pipes gets:
  - sb_state_t enum {RUN, CSR_WAIT, DRAIN};
  - sb_cnt_t (logic [CNT_W-1:0]);
  - a kill_slot_t struct {valid, wen, iscsr, dst}.
- Sub-module sb_regcnt: one saturating counter with an inc input, three dec inputs and an underflow flag. It is instantiated NREG-1 times via generate.

Test Plan:
- Issue addi x5 (wen, dst=5); next cycle issue add x6,x5,x0 → ready=0. Retire x5 → ready=1 one cycle later. Check busy_vec[5] goes 1→0 and stall_cycles=count of stalled cycles.
- Fire three back-to-back writers to x7 with CNT_W=2 → the 4th writer to x7 stalls (cnt=3=MAX). Retire one → it fires.
- Same cycle: fire writer x9 and retire x9 with cnt[9]=1 → cnt[9] stays 1 and busy_vec[9]=1.
- Fire CSR → state CSR_WAIT and a following add stalls. Assert kill0_valid&iscsr → RUN next cycle and the add fires.
- Fence with cnt[3]=2 → DRAIN. Retire x3 twice → RUN, and the fence fires the cycle after empty.
- Retire x4 with cnt[4]=0 → sb_err=1 stays high. Then async reset=0 mid-DRAIN → state=RUN, all counters 0, sb_err=0 immediately.
